// File: rtl/pipe_hazard_ctrl.sv
// Y86 five-stage pipeline control: hazard stall/bubble generation plus run/drain/halt freeze FSM.
// Optional hazard performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_Ins_Code,
  input  logic [3:0]  E_Ins_Code,
  input  logic [3:0]  M_Ins_Code,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_tostall,
  output logic        D_tostall,
  output logic        D_toBubble,
  output logic        E_toBubble,
  output logic        M_toBubble,
  output logic        W_tostall,
  output logic        set_cc_en,
  output logic        cpu_halted,
  output logic [2:0]  prog_stat
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_bubbles
`endif
);

  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] prog_stat_q, prog_stat_d;

  logic loaduse, ret, mispred, mexc, wexc;

  assign loaduse = ((E_Ins_Code == I_MRMOV) || (E_Ins_Code == I_POP)) &&
                   (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret     = (D_Ins_Code == I_RET) || (E_Ins_Code == I_RET) || (M_Ins_Code == I_RET);
  assign mispred = (E_Ins_Code == I_JXX) && !e_Cnd;
  assign mexc    = (m_stat == 3'd1) || (m_stat == 3'd2) || (m_stat == 3'd3);
  assign wexc    = (W_stat == 3'd1) || (W_stat == 3'd2) || (W_stat == 3'd3);

  always_comb begin
    state_d     = state_q;
    prog_stat_d = prog_stat_q;
    F_tostall   = loaduse | ret;
    D_tostall   = loaduse;
    D_toBubble  = mispred | (ret & !loaduse);
    E_toBubble  = mispred | loaduse;
    M_toBubble  = mexc | wexc;
    W_tostall   = wexc;
    set_cc_en   = (E_Ins_Code == I_OPQ) & !mexc & !wexc;
    cpu_halted  = 1'b0;

    case (state_q)
      ST_HALT: begin
        F_tostall  = 1'b1;
        D_tostall  = 1'b1;
        D_toBubble = 1'b0;
        E_toBubble = 1'b1;
        M_toBubble = 1'b1;
        W_tostall  = 1'b1;
        set_cc_en  = 1'b0;
        cpu_halted = 1'b1;
      end
      ST_RUN, ST_DRAIN: begin
        // Nothing new is fetched behind a faulting instruction until it retires or is squashed.
        if (state_q == ST_DRAIN) F_tostall = 1'b1;
        if (wexc) begin
          state_d     = ST_HALT;
          prog_stat_d = W_stat;
        end else if (mexc) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      prog_stat_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      prog_stat_q <= prog_stat_d;
    end
  end

  assign prog_stat = prog_stat_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, stl_q, bub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      stl_q <= 32'd0;
      bub_q <= 32'd0;
    end else if (state_q != ST_HALT) begin
      cyc_q <= cyc_q + 32'd1;
      if (D_tostall)               stl_q <= stl_q + 32'd1;
      if (E_toBubble | D_toBubble) bub_q <= bub_q + 32'd1;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_stalls  = stl_q;
  assign perf_bubbles = bub_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a behavioural model of the hazard rules and freeze behaviour.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  D_Ins_Code, E_Ins_Code, M_Ins_Code;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_tostall, D_tostall, D_toBubble, E_toBubble, M_toBubble, W_tostall, set_cc_en;
  logic        cpu_halted;
  logic [2:0]  prog_stat;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stalls, perf_bubbles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .D_Ins_Code(D_Ins_Code), .E_Ins_Code(E_Ins_Code), .M_Ins_Code(M_Ins_Code),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_tostall(F_tostall), .D_tostall(D_tostall), .D_toBubble(D_toBubble),
    .E_toBubble(E_toBubble), .M_toBubble(M_toBubble), .W_tostall(W_tostall),
    .set_cc_en(set_cc_en), .cpu_halted(cpu_halted), .prog_stat(prog_stat)
`ifdef PIPE_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_bubbles(perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The machine is frozen after an excepting instruction reaches W; it is draining
  // exactly when an exception sat in M on the previous cycle.
  bit         mdl_frozen;
  bit         mdl_draining;
  logic [2:0] mdl_stat;
  int unsigned mdl_cyc, mdl_stl, mdl_bub;

  function automatic bit is_exc(input logic [2:0] s);
    return s inside {3'd1, 3'd2, 3'd3};
  endfunction

  // Returns {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  function automatic logic [6:0] expect_ctrl();
    bit lu, rt, mp, me, we;
    logic [6:0] r;
    lu = (E_Ins_Code == 4'h5 || E_Ins_Code == 4'hB) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = (D_Ins_Code == 4'h9) || (E_Ins_Code == 4'h9) || (M_Ins_Code == 4'h9);
    mp = (E_Ins_Code == 4'h7) && !e_Cnd;
    me = is_exc(m_stat);
    we = is_exc(W_stat);
    if (mdl_frozen) return 7'b1101110;
    r[6] = lu || rt || mdl_draining;
    r[5] = lu;
    r[4] = !lu && (mp || rt);
    r[3] = mp || lu;
    r[2] = me || we;
    r[1] = we;
    r[0] = (E_Ins_Code == 4'h6) && !me && !we;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [6:0] c;
    if (!rst_n) begin
      mdl_frozen = 0; mdl_draining = 0; mdl_stat = 3'd0;
      mdl_cyc = 0; mdl_stl = 0; mdl_bub = 0;
    end else if (!mdl_frozen) begin
      c = expect_ctrl();
      mdl_cyc++;
      if (c[5]) mdl_stl++;
      if (c[4] || c[3]) mdl_bub++;
      if (is_exc(W_stat)) begin
        mdl_frozen = 1; mdl_stat = W_stat; mdl_draining = 0;
      end else begin
        mdl_draining = is_exc(m_stat);
      end
    end
  end

  int fail_prints = 0;
  task automatic note_fail(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_fail++;
    if (fail_prints < 40) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      fail_prints++;
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [6:0] got;
    logic [6:0] exp;
    got = {F_tostall, D_tostall, D_toBubble, E_toBubble, M_toBubble, W_tostall, set_cc_en};
    exp = expect_ctrl();
    n_tests++; if (got !== exp) note_fail("model_ctrl", 32'(got), 32'(exp));
    n_tests++; if (cpu_halted !== mdl_frozen) note_fail("model_halted", 32'(cpu_halted), 32'(mdl_frozen));
    n_tests++; if (prog_stat !== mdl_stat) note_fail("model_prog_stat", 32'(prog_stat), 32'(mdl_stat));
    n_tests++; if ((D_tostall & D_toBubble) !== 1'b0) note_fail("d_stall_and_bubble", 32'(D_toBubble), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    n_tests++; if (perf_cycles !== mdl_cyc) note_fail("model_perf_cycles", perf_cycles, mdl_cyc);
    n_tests++; if (perf_stalls !== mdl_stl) note_fail("model_perf_stalls", perf_stalls, mdl_stl);
    n_tests++; if (perf_bubbles !== mdl_bub) note_fail("model_perf_bubbles", perf_bubbles, mdl_bub);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) note_fail(nm, act, exp);
  endtask

  task automatic setin(input logic [3:0] di, input logic [3:0] ei, input logic [3:0] mi,
                       input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb,
                       input logic cnd, input logic [2:0] ms, input logic [2:0] ws);
    @(posedge clk); #1;
    D_Ins_Code = di; E_Ins_Code = ei; M_Ins_Code = mi;
    E_dstM = dm; d_srcA = sa; d_srcB = sb; e_Cnd = cnd;
    m_stat = ms; W_stat = ws;
    #1;
  endtask

  task automatic neutral();
    setin(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
  endtask

  function automatic logic [6:0] ctrls();
    return {F_tostall, D_tostall, D_toBubble, E_toBubble, M_toBubble, W_tostall, set_cc_en};
  endfunction

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rnd_icode();
    if ($urandom_range(0, 15) == 0) return 4'($urandom_range(12, 15));
    return 4'($urandom_range(0, 11));
  endfunction

  function automatic logic [2:0] rnd_stat();
    if ($urandom_range(0, 30) == 0) return 3'($urandom_range(1, 3));
    if ($urandom_range(0, 60) == 0) return 3'($urandom_range(4, 7));
    return 3'd0;
  endfunction

  initial begin
    int halt_run;
    rst_n = 1'b0;
    D_Ins_Code = 4'h1; E_Ins_Code = 4'h1; M_Ins_Code = 4'h1;
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b1;
    m_stat = 3'd0; W_stat = 3'd0;
    #3;
    chk("reset_halted", 32'(cpu_halted), 32'd0);
    chk("reset_prog_stat", 32'(prog_stat), 32'd0);
    chk("reset_ctrls", 32'(ctrls()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load/use
    setin(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("loaduse_ctrls", 32'(ctrls()), 32'b1101000);
    setin(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("loaduse_none", 32'(ctrls()), 32'd0);

    // Mispredict with RET in D, then taken branch
    setin(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0, 3'd0);
    chk("mispred_ret", 32'(ctrls()), 32'b1011000);
    setin(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("branch_taken", 32'(ctrls()), 32'd0);

    // RET walking D -> E -> M
    setin(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("ret_in_d", 32'(ctrls()), 32'b1010000);
    setin(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("ret_in_e", 32'(ctrls()), 32'b1010000);
    setin(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("ret_in_m", 32'(ctrls()), 32'b1010000);
    setin(4'h1, 4'h5, 4'h9, 4'h2, 4'hF, 4'h2, 1'b1, 3'd0, 3'd0);
    chk("ret_loaduse", 32'(ctrls()), 32'b1101000);

    // OPQ sets CC normally
    setin(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("opq_cc", 32'(ctrls()), 32'b0000001);

    // Squashed exception: one cycle in DRAIN then back to RUN
    setin(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd3, 3'd0);
    chk("squash_mexc", 32'(ctrls()), 32'b0000100);
    setin(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    chk("squash_drain_fstall", 32'(ctrls()), 32'b1000000);
    neutral();
    chk("squash_back_run", 32'(ctrls()), 32'd0);
    chk("squash_not_halted", 32'(cpu_halted), 32'd0);

    // Exception drains then halts
    setin(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd2, 3'd0);
    chk("exc_m_ctrls", 32'(ctrls()), 32'b0000100);
    setin(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd2);
    chk("exc_w_ctrls", 32'(ctrls()), 32'b1000110);
    chk("exc_w_not_yet_halted", 32'(cpu_halted), 32'd0);
    setin(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0, 3'd0);
    chk("halt_flag", 32'(cpu_halted), 32'd1);
    chk("halt_prog_stat", 32'(prog_stat), 32'd2);
    chk("halt_ctrls", 32'(ctrls()), 32'b1101110);
    repeat (12) setin(4'($urandom_range(0, 15)), 4'h6, 4'h9, 4'h1, 4'h1, 4'h1, 1'b0, 3'd0, 3'd3);
    chk("halt_sticky", 32'(cpu_halted), 32'd1);
    chk("halt_stat_sticky", 32'(prog_stat), 32'd2);

    // Asynchronous reset mid-cycle while halted
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_halted", 32'(cpu_halted), 32'd0);
    chk("async_rst_stat", 32'(prog_stat), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

`ifdef PIPE_PERF_CNT_EN
    D_Ins_Code = 4'h1; E_Ins_Code = 4'h1; M_Ins_Code = 4'h1;
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b1;
    m_stat = 3'd0; W_stat = 3'd0;
    repeat (100) @(posedge clk);
    #1;
    chk("perf_cycles_100", perf_cycles, 32'd100);
    chk("perf_stalls_0", perf_stalls, 32'd0);
`endif

    // Randomized phase; leave HALT via reset after a few frozen cycles
    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      setin(rnd_icode(), rnd_icode(), rnd_icode(), rnd_reg(), rnd_reg(), rnd_reg(),
            1'($urandom_range(0, 1)), rnd_stat(), rnd_stat());
      if (cpu_halted) halt_run++;
      else halt_run = 0;
      if (halt_run > 4) begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        halt_run = 0;
      end
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the five-stage Y86 pipeline. Observes the instruction codes, register IDs, branch outcome and status codes in the F/D/E/M/W stages and drives the stall/bubble controls of every pipeline register, including the decode register's `D_tostall`/`D_toBubble`, plus the condition-code write enable. It holds a small run/drain/halt state machine that freezes the machine once an exception retires. Under an optional build feature it also keeps hazard performance counters.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk`  in  1  pipeline clock; state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `D_Ins_Code`  in  4  icode in the decode stage.
- `E_Ins_Code`  in  4  icode in the execute stage.
- `M_Ins_Code`  in  4  icode in the memory stage.
- `d_srcA`, `d_srcB`  in  4 each  source registers being read in decode; 4'hF means none.
- `E_dstM`  in  4  load destination register in execute; 4'hF means none.
- `e_Cnd`  in  1  branch condition computed in execute.
- `m_stat`  in  3  status out of the memory stage.
- `W_stat`  in  3  status in the writeback register.
- `F_tostall`, `D_tostall`, `D_toBubble`, `E_toBubble`, `M_toBubble`, `W_tostall`  out  1 each  pipeline register controls.
- `set_cc_en`  out  1  condition-code write enable.
- `cpu_halted`  out  1  machine frozen; sticky until reset.
- `prog_stat`  out  3  status of the instruction that caused the halt.
- `perf_cycles`, `perf_stalls`, `perf_bubbles`  out  32 each  performance counters; present only with `PIPE_PERF_CNT_EN`.

## Operation
- **icodes:** HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
- **stat codes:** 0=AOK (also the bubble value), 1=HLT, 2=ADR, 3=INS. "exc(x)" means x is 1, 2 or 3.
- **Hazard terms:**
  - loaduse = E_icode∈{MRMOV,POP} && E_dstM≠F && E_dstM∈{d_srcA,d_srcB}.
  - ret = RET∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX && !e_Cnd.
  - mexc = exc(m_stat).
  - wexc = exc(W_stat).
- **Controls in state RUN or DRAIN** (combinational from inputs and state):
  - `F_tostall` = loaduse | ret.
  - `D_tostall` = loaduse.
  - `D_toBubble` = mispred | (ret & !loaduse).
  - `E_toBubble` = mispred | loaduse.
  - `M_toBubble` = mexc | wexc.
  - `W_tostall` = wexc.
  - `set_cc_en` = E_icode==OPQ & !mexc & !wexc.
- **State machine** (state register 2 bits):
  - RUN→DRAIN when mexc & !wexc.
  - RUN or DRAIN→HALT when wexc; capture `prog_stat` ← W_stat in the same edge.
  - DRAIN→RUN when !mexc & !wexc. This covers an exception squashed by a mispredict.
  - HALT is absorbing until reset.
- **In DRAIN:** same equations as RUN, and additionally `F_tostall`=1 so no new fetch enters behind the faulting instruction.
- **In HALT:**
  - `F_tostall`=`D_tostall`=`W_tostall`=1.
  - `E_toBubble`=`M_toBubble`=1.
  - `D_toBubble`=0 and `set_cc_en`=0.
  - `cpu_halted`=1.
- A bubble and a stall are never both asserted for the same register. Stall wins, as in the `D_toBubble` term above.

## Timing
- All control outputs are combinational. They are valid before the rising edge at which the pipeline registers sample them; latency is 0 cycles.
- State, `prog_stat` and the counters update on `posedge clk`.
- **Reset** (asynchronous assert, synchronous-safe release): state=RUN, `prog_stat`=0, `cpu_halted`=0, counters=0. Control outputs then follow their equations with state RUN.
- **Reset during HALT or DRAIN:** the state returns to RUN immediately, without waiting for a clock edge.
- **Simultaneous events:**
  - loaduse + ret: F stalls, D stalls, E bubbles, and D does not bubble.
  - mispred + ret (RET in D): D bubbles and E bubbles.
  - wexc and mexc together: the state goes to HALT, and `prog_stat` takes W_stat.
- A halt due to HLT is entered on the edge where the HALT instruction sits in W. `cpu_halted` rises one cycle after W_stat=1 is first presented.

## Configuration
- `PIPE_PERF_CNT_EN`, when defined:
  - `perf_cycles` increments every cycle while the state is not HALT.
  - `perf_stalls` increments on cycles with `D_tostall`=1 outside HALT.
  - `perf_bubbles` increments on cycles with `E_toBubble`|`D_toBubble`=1 outside HALT.
  - All three counters are 32-bit and wrap at 2^32−1→0, and they freeze in HALT.
- When `PIPE_PERF_CNT_EN` is undefined, the three ports and their registers are absent.

## Test plan
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 → `F_tostall`=`D_tostall`=`E_toBubble`=1, `D_toBubble`=0. Repeat with d_srcA=F, d_srcB=F → all controls 0.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=9 → `D_toBubble`=`E_toBubble`=1, `F_tostall`=1 (RET in D). Repeat with e_Cnd=1 and D_icode=1 → all controls 0.
- ret walk: RET in D for 1 cycle, then E, then M → `F_tostall`=`D_toBubble`=1 for 3 consecutive cycles. With E_icode=5, E_dstM=d_srcB concurrently → `D_tostall`=1, `D_toBubble`=0.
- Exception drain and halt: m_stat=2 with E_icode=6 → `M_toBubble`=1, `set_cc_en`=0, state DRAIN, `F_tostall`=1. Next cycle W_stat=2 → `W_tostall`=1, then `cpu_halted`=1, `prog_stat`=2, and the state stays HALT for 10+ cycles.
- Squashed exception: m_stat=3 for one cycle, then m_stat=0 and W_stat=0 → state returns to RUN and `cpu_halted` stays 0.
- Reset: assert `rst_n`=0 mid-cycle while in HALT → `cpu_halted`=0 and `prog_stat`=0 immediately. With `PIPE_PERF_CNT_EN`: 100 free cycles after reset → `perf_cycles`=100; a counter preloaded to FFFFFFFF wraps to 0.
